// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU packet path.
// Provides opcode constants, the fixed header length and the parser state encoding.
package uart_alu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] OP_ECHO = 8'hEC;
  localparam logic [BYTE_W-1:0] OP_ADD  = 8'hAD;
  localparam logic [BYTE_W-1:0] OP_MUL  = 8'h88;
  localparam logic [BYTE_W-1:0] OP_DIV  = 8'h24;

  // Opcode, reserved, length LSB, length MSB.
  localparam logic [LEN_W-1:0] HDR_LEN = 16'd4;
  // Smallest accepted packet: header plus one payload word.
  localparam logic [LEN_W-1:0] MIN_LEN = 16'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RSV     = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_EMIT    = 3'd5,
    ST_DROP    = 3'd6
  } state_e;

  // True for the four opcodes the ALU understands.
  function automatic logic op_valid(input logic [BYTE_W-1:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_pkt_parser.sv
// Byte-stream packet parser: turns a UART byte stream into 32-bit payload words.
// Frame: opcode, reserved, len_lo, len_hi, then (len-4) payload bytes, little-endian words.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   s_axis_tdata/tvalid_i     incoming byte stream; s_axis_tready_o accepts it
//   m_cmd_o, m_word_o         opcode and assembled word, held while m_valid_o
//   m_valid_o, m_ready_i      word handshake; m_last_o marks the final word
//   err_o                     one-cycle pulse when a header is rejected
//   busy_o                    high whenever the parser is not idle
module alu_pkt_parser
  import uart_alu_pkg::*;
#(
  parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [BYTE_W-1:0] s_axis_tdata_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  output logic [BYTE_W-1:0] m_cmd_o,
  output logic [WORD_W-1:0] m_word_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              err_o,
  output logic              busy_o
);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [BYTE_W-1:0]   len_lo_q, len_lo_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                xfer;
  logic [LEN_W-1:0]    hdr_len;
  logic                len_too_long;
  logic                hdr_ok;

  // Input is stalled only while a word waits for downstream, and during reset.
  assign s_axis_tready_o = !reset_i && (state_q != ST_EMIT);
  assign xfer            = s_axis_tvalid_i && s_axis_tready_o;

  // Header check evaluated as the length MSB arrives.
  assign hdr_len      = {s_axis_tdata_i, len_lo_q};
  assign len_too_long = 17'(hdr_len) > 17'(MAX_LEN);
  assign hdr_ok       = op_valid(cmd_q) && (hdr_len >= MIN_LEN) && !len_too_long &&
                        (hdr_len[1:0] == 2'b00);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_lo_d = len_lo_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          cmd_d   = s_axis_tdata_i;
          state_d = ST_RSV;
        end
      end
      ST_RSV: begin
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_lo_d = s_axis_tdata_i;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          if (hdr_ok) begin
            cnt_d   = hdr_len - HDR_LEN;
            idx_d   = 2'd0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d = 1'b1;
            // Swallow whatever payload the sender still transmits.
            if (hdr_len > HDR_LEN) begin
              cnt_d   = hdr_len - HDR_LEN;
              state_d = ST_DROP;
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          // Shift in from the top so byte 0 ends up in bits [7:0].
          word_d = {s_axis_tdata_i, word_q[WORD_W-1:BYTE_W]};
          cnt_d  = cnt_q - 16'd1;
          idx_d  = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            valid_d = 1'b1;
            last_d  = (cnt_q == 16'd1);
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (m_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = (cnt_q == '0) ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (xfer) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign m_cmd_o   = cmd_q;
  assign m_word_o  = word_q;
  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_alu_pkt_parser.sv
// Directed bench for alu_pkt_parser: good packets, back-pressure, rejected headers, reset mid-packet.
module tb_alu_pkt_parser;

  logic        clk;
  logic        reset_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_cmd;
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int err_cnt    = 0;
  int valid_cnt  = 0;
  logic both_seen = 1'b0;
  int e0;
  int v0;

  alu_pkt_parser #(.MAX_LEN(16'hFFFF)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .s_axis_tdata_i  (s_axis_tdata),
    .s_axis_tvalid_i (s_axis_tvalid),
    .s_axis_tready_o (s_axis_tready),
    .m_cmd_o         (m_cmd),
    .m_word_o        (m_word),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_last_o        (m_last),
    .err_o           (err),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the settled values just before each edge.
  always @(posedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (m_valid) valid_cnt <= valid_cnt + 1;
    if (m_valid && s_axis_tready) both_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and return at the negedge after it has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!s_axis_tready) begin
      chk("send_timeout", 32'(s_axis_tready), 32'd1);
    end else begin
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  initial begin
    reset_i       = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_ready       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tready_low", 32'(s_axis_tready), 32'd0);
    reset_i = 1'b0;
    #1;
    chk("rst_tready_high", 32'(s_axis_tready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_word", m_word, 32'h0);
    chk("rst_cmd", 32'(m_cmd), 32'h0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // ECHO, one word
    send_hdr(8'hEC, 16'h0008);
    send_word(32'hDEADBEEF);
    chk("echo_valid", 32'(m_valid), 32'd1);
    chk("echo_word", m_word, 32'hDEADBEEF);
    chk("echo_cmd", 32'(m_cmd), 32'hEC);
    chk("echo_last", 32'(m_last), 32'd1);
    chk("echo_tready", 32'(s_axis_tready), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("echo_valid_drop", 32'(m_valid), 32'd0);
    chk("echo_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("echo_no_err", 32'(err_cnt), 32'd0);

    // ADD, two words with back-pressure
    send_hdr(8'hAD, 16'h000C);
    send_word(32'h00000001);
    chk("add_w1", m_word, 32'h1);
    chk("add_w1_last", 32'(m_last), 32'd0);
    chk("add_cmd", 32'(m_cmd), 32'hAD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("add_w1_hold_valid", 32'(m_valid), 32'd1);
      chk("add_w1_hold_word", m_word, 32'h1);
      chk("add_w1_hold_last", 32'(m_last), 32'd0);
      chk("add_w1_hold_tready", 32'(s_axis_tready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("add_between_valid", 32'(m_valid), 32'd0);
    send_word(32'h00000002);
    chk("add_w2", m_word, 32'h2);
    chk("add_w2_last", 32'(m_last), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("add_w2_hold_valid", 32'(m_valid), 32'd1);
      chk("add_w2_hold_word", m_word, 32'h2);
      chk("add_w2_hold_last", 32'(m_last), 32'd1);
      chk("add_w2_hold_cmd", 32'(m_cmd), 32'hAD);
      chk("add_w2_hold_tready", 32'(s_axis_tready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("add_idle", 32'(busy), 32'd0);

    // Invalid opcode, payload dropped, then a good packet
    @(negedge clk);
    e0 = err_cnt;
    v0 = valid_cnt;
    send_hdr(8'h55, 16'h0008);
    chk("badop_err", 32'(err), 32'd1);
    chk("badop_busy", 32'(busy), 32'd1);
    send_word(32'h12345678);
    chk("badop_err_gone", 32'(err), 32'd0);
    chk("badop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("badop_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("badop_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_hdr(8'hEC, 16'h0008);
    send_word(32'h44332211);
    chk("after_bad_word", m_word, 32'h44332211);
    chk("after_bad_cmd", 32'(m_cmd), 32'hEC);
    chk("after_bad_last", 32'(m_last), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // Length 7: not a word multiple, 3 bytes dropped
    @(negedge clk);
    e0 = err_cnt;
    send_hdr(8'hEC, 16'h0007);
    chk("len7_err", 32'(err), 32'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    chk("len7_still_drop", 32'(busy), 32'd1);
    send_byte(8'hA3);
    chk("len7_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len7_err_pulses", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of an ADD payload
    send_hdr(8'hAD, 16'h000C);
    send_byte(8'h01);
    send_byte(8'h02);
    reset_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_word", m_word, 32'h0);
    chk("mid_rst_cmd", 32'(m_cmd), 32'h0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    reset_i = 1'b0;
    #1;
    chk("post_rst_tready", 32'(s_axis_tready), 32'd1);
    m_ready = 1'b1;
    v0 = valid_cnt;
    send_hdr(8'hAD, 16'h000C);
    send_word(32'h08070605);
    chk("post_rst_w1", m_word, 32'h08070605);
    chk("post_rst_w1_valid", 32'(m_valid), 32'd1);
    chk("post_rst_w1_last", 32'(m_last), 32'd0);
    send_word(32'h0D0C0B0A);
    chk("post_rst_w2", m_word, 32'h0D0C0B0A);
    chk("post_rst_w2_last", 32'(m_last), 32'd1);
    @(negedge clk);
    m_ready = 1'b0;
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("post_rst_word_count", 32'(valid_cnt - v0), 32'd2);

    // Length 4: rejected, nothing to drop
    e0 = err_cnt;
    send_hdr(8'hEC, 16'h0004);
    chk("len4_err", 32'(err), 32'd1);
    chk("len4_idle", 32'(busy), 32'd0);
    chk("len4_tready", 32'(s_axis_tready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("len4_err_pulses", 32'(err_cnt - e0), 32'd1);

    chk("valid_tready_exclusive", 32'(both_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
